// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side output stage.
package fifo_pkg;

    localparam int unsigned DATASIZE_DEFAULT = 8;

    // Buffer occupancy, legal range 0..2.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd2;

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// Read-side bundle: pop/empty/data from the pointer logic and memory, plus the
// downstream valid/ready stream. master = the output stage, slave = its surroundings.
interface fifo_rd_fwft_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEFAULT
);
    logic                rempty;
    logic [DATASIZE-1:0] rdata;
    logic                rinc;
    logic                m_valid;
    logic [DATASIZE-1:0] m_data;
    logic                m_ready;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_valid, m_data
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_buf2.sv
// Two-entry shift buffer: slot0 is the head, slot1 the second entry.
// clr drops the occupancy without touching the slot contents.
module fifo_rd_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                push,
    input  logic                pop,
    input  logic [DATASIZE-1:0] din,
    output logic [DATASIZE-1:0] head,
    output occ_t                occ
);
    logic [DATASIZE-1:0] slot0;
    logic [DATASIZE-1:0] slot1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clr) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the incoming word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage: credit-based fetches into a 2-word buffer.
// Optional synchronous flush input enabled by defining FIFO_RD_FLUSH_EN.
module fifo_rd_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEFAULT,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic rclk,
    input  logic rrst,
`ifdef FIFO_RD_FLUSH_EN
    input  logic rflush,
`endif
    fifo_rd_fwft_if.master bus
);
    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("fifo_rd_fwft: only RD_LAT=1 is supported");
    end

    logic       flush;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;
    occ_t       occ;

`ifdef FIFO_RD_FLUSH_EN
    assign flush = rflush;
`else
    assign flush = 1'b0;
`endif

    assign pop    = bus.m_valid & bus.m_ready;
    // Words held plus the one returning, minus the one leaving this cycle.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign bus.rinc    = ~rrst & ~flush & ~bus.rempty & (credit < 3'd2);
    assign bus.m_valid = (occ != '0);

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.rinc;
        end
    end

    fifo_rd_buf2 #(
        .DATASIZE(DATASIZE)
    ) u_buf (
        .clk  (rclk),
        .rst  (rrst),
        .clr  (flush),
        .push (inflight),
        .pop  (pop),
        .din  (bus.rdata),
        .head (bus.m_data),
        .occ  (occ)
    );

    a_credit_bound : assert property (@(posedge rclk) disable iff (rrst)
        (({1'b0, occ} + {2'b0, inflight}) <= {1'b0, OCC_MAX}));

    a_no_rinc_when_empty : assert property (@(posedge rclk) disable iff (rrst)
        !(bus.rinc && bus.rempty));

    a_hold_stable : assert property (@(posedge rclk) disable iff (rrst)
        (bus.m_valid && !bus.m_ready && !flush) |=> $stable(bus.m_data));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: memory/pointer environment plus an index-based reference
// of the FWFT stream (word order, occupancy, fetch credit).
module tb_fifo_rd_fwft;
    import fifo_pkg::*;

    localparam int unsigned W     = DATASIZE_DEFAULT;
    localparam int unsigned MEMSZ = 1024;
`ifdef FIFO_RD_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    logic rclk = 1'b0;
    logic rrst;
`ifdef FIFO_RD_FLUSH_EN
    logic rflush;
`endif

    always #5 rclk = ~rclk;

    fifo_rd_fwft_if #(.DATASIZE(W)) bus ();

    fifo_rd_fwft #(
        .DATASIZE(W),
        .RD_LAT  (1)
    ) dut (
        .rclk  (rclk),
        .rrst  (rrst),
`ifdef FIFO_RD_FLUSH_EN
        .rflush(rflush),
`endif
        .bus   (bus)
    );

    // Memory contents written by the producer side; wr_cnt words are available.
    logic [W-1:0] mem [MEMSZ];
    int unsigned  wr_cnt;
    int unsigned  rd_ptr;    // next index the pointer logic will pop
    int unsigned  next_out;  // index of the word that must appear at the head
    int           held;      // words the stage should be holding
    bit           inflight_m;
    int           checks;
    int           errors;
    int           rinc_seen;
    int           pops_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input logic [W-1:0] d);
        if (wr_cnt < MEMSZ) begin
            mem[wr_cnt] = d;
            wr_cnt++;
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input bit rdy, input bit fl);
        bit          empty;
        bit          fl_eff;
        bit          pop_e;
        bit          rinc_e;
        int          outstanding;
        int unsigned fetch_idx;
        empty  = (rd_ptr >= wr_cnt);
        fl_eff = fl && HAS_FLUSH;
        bus.rempty  = empty;
        bus.m_ready = rdy;
`ifdef FIFO_RD_FLUSH_EN
        rflush = fl_eff;
`endif
        #1;
        pop_e       = (held != 0) && rdy;
        outstanding = held + (inflight_m ? 1 : 0) - (pop_e ? 1 : 0);
        rinc_e      = !empty && !fl_eff && (outstanding < 2);

        chk("m_valid", 32'(bus.m_valid), 32'(held != 0));
        if (held != 0) chk("m_data", 32'(bus.m_data), 32'(mem[next_out]));
        chk("rinc", 32'(bus.rinc), 32'(rinc_e));
        if (bus.rinc === 1'b1) rinc_seen++;
        if (bus.m_valid === 1'b1 && rdy) pops_seen++;

        fetch_idx = rd_ptr;
        if (rinc_e) rd_ptr++;
        @(posedge rclk);
        if (pop_e) begin
            held--;
            next_out++;
        end
        if (inflight_m) held++;
        inflight_m = rinc_e;
        if (fl_eff) begin
            held       = 0;
            inflight_m = 1'b0;
            next_out   = rd_ptr;
        end
        #1;
        bus.rdata = rinc_e ? mem[fetch_idx] : W'($urandom);
        @(negedge rclk);
    endtask

    task automatic pulse_reset(input int unsigned n);
        rrst        = 1'b1;
        bus.rempty  = (rd_ptr >= wr_cnt);
        held        = 0;
        inflight_m  = 1'b0;
        next_out    = rd_ptr;
        for (int unsigned i = 0; i < n; i++) begin
            #1;
            chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
            chk("rst_rinc", 32'(bus.rinc), 32'(0));
            chk("rst_m_data", 32'(bus.m_data), 32'(0));
            @(posedge rclk);
            #1;
            bus.rdata = W'($urandom);
            @(negedge rclk);
        end
        rrst = 1'b0;
    endtask

    initial begin
        int unsigned idx;
        rrst        = 1'b1;
        bus.rempty  = 1'b1;
        bus.m_ready = 1'b1;
        bus.rdata   = '0;
`ifdef FIFO_RD_FLUSH_EN
        rflush = 1'b0;
`endif
        wr_cnt = 0; rd_ptr = 0; next_out = 0; held = 0; inflight_m = 1'b0;
        checks = 0; errors = 0; rinc_seen = 0; pops_seen = 0;

        // Reset with the FIFO empty and downstream ready.
        @(negedge rclk);
        pulse_reset(3);
        cycle(1'b1, 1'b0);

        // First word: fetch in c0, visible on the output in c2.
        add_word(W'(8'hA5));
        rinc_seen = 0;
        cycle(1'b1, 1'b0);
        chk("lat_rinc_c0", 32'(rinc_seen), 32'(1));
        cycle(1'b1, 1'b0);
        #1;
        chk("lat_valid_c2", 32'(bus.m_valid), 32'(1));
        chk("lat_data_c2", 32'(bus.m_data), 32'(8'hA5));
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Sustained streaming of an incrementing sequence.
        for (int unsigned i = 1; i <= 20; i++) add_word(W'(i));
        rinc_seen = 0; pops_seen = 0;
        for (int unsigned i = 0; i < 24; i++) cycle(1'b1, 1'b0);
        chk("stream_rinc_count", 32'(rinc_seen), 32'(20));
        chk("stream_pops", 32'(pops_seen), 32'(20));

        // Backpressure: only two fetches while blocked, then drain in order.
        for (int unsigned i = 0; i < 5; i++) add_word(W'($urandom));
        rinc_seen = 0; pops_seen = 0;
        for (int unsigned i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        chk("bp_rinc_count", 32'(rinc_seen), 32'(2));
        for (int unsigned i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        chk("bp_pops", 32'(pops_seen), 32'(5));

        // Randomized arrivals and backpressure.
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0 && (i % 100) < 80) add_word(W'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        for (int unsigned i = 0; i < 12; i++) cycle(1'b1, 1'b0);

        // Reset while streaming; the first output afterwards is the first post-reset fetch.
        for (int unsigned i = 0; i < 10; i++) add_word(W'($urandom));
        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        pulse_reset(1);
        idx = rd_ptr;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        #1;
        chk("post_rst_valid", 32'(bus.m_valid), 32'(1));
        chk("post_rst_data", 32'(bus.m_data), 32'(mem[idx]));
        for (int unsigned i = 0; i < 14; i++) cycle(1'b1, 1'b0);

        // Flush while streaming (no-op in the default build).
        for (int unsigned i = 0; i < 10; i++) add_word(W'($urandom));
        for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int unsigned i = 0; i < 16; i++) cycle(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
